// File: rtl/instr_sequencer_pkg.sv
// Shared opcode constants and sequencer state encoding.
// Opcodes 0000..0111 and NOP are shared with the CU decoder.
package instr_sequencer_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_MUL    = 4'b0010;
    localparam logic [3:0] OP_MEMW   = 4'b0011;
    localparam logic [3:0] OP_MEMSEL = 4'b0100;
    localparam logic [3:0] OP_SIG    = 4'b0101;
    localparam logic [3:0] OP_RELU   = 4'b0110;
    localparam logic [3:0] OP_SIGD   = 4'b0111;
    localparam logic [3:0] OP_NOP    = 4'b1111;

    localparam logic [3:0] OP_LOOP   = 4'b1000;
    localparam logic [3:0] OP_SETCNT = 4'b1001;

    localparam logic [11:0] HALT_OPERAND = 12'hFFF;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StDone
    } state_e;

endpackage

// File: rtl/instr_sequencer.sv
// Fetches instruction words, runs LOOP/SETCNT internally and issues the rest
// to the CU one at a time; the CU sees NOP whenever nothing is issued.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned OP_WIDTH    = 4,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   stall,
    output logic                   imem_en,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [OP_WIDTH-1:0]    opcode,
    output logic [11:0]            operand,
    output logic                   instr_valid,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam logic [OP_WIDTH-1:0]   Nop    = OP_WIDTH'(OP_NOP);
    localparam logic [ADDR_WIDTH-1:0] PcLast = '1;

    state_e               state;
    logic [CNT_WIDTH-1:0] loop_cnt;

    logic [OP_WIDTH-1:0] dec_op;
    logic [11:0]         dec_opnd;
    logic                dec_halt;
    logic                dec_issue;
    logic                dec_illegal;
    logic                pc_last;

    always_comb begin
        dec_op      = imem_rdata[INSTR_WIDTH-1 -: OP_WIDTH];
        dec_opnd    = imem_rdata[11:0];
        dec_halt    = (dec_op == Nop) && (dec_opnd == HALT_OPERAND);
        dec_issue   = !dec_op[OP_WIDTH-1] || ((dec_op == Nop) && !dec_halt);
        dec_illegal = dec_op[OP_WIDTH-1] && (dec_op != Nop) &&
                      (dec_op != OP_WIDTH'(OP_LOOP)) && (dec_op != OP_WIDTH'(OP_SETCNT));
        pc_last     = (pc == PcLast);
    end

    assign imem_en   = (state == StFetch);
    assign imem_addr = pc;
    assign busy      = (state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            pc          <= '0;
            loop_cnt    <= '0;
            opcode      <= Nop;
            operand     <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else if (abort) begin
            // pc and loop_cnt are kept until the next start
            state       <= StIdle;
            opcode      <= Nop;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        pc       <= '0;
                        loop_cnt <= '0;
                        err      <= 1'b0;
                        state    <= StFetch;
                    end
                end
                StFetch: state <= StDecode;
                StDecode: begin
                    if (dec_issue) begin
                        opcode      <= dec_op;
                        operand     <= dec_opnd;
                        instr_valid <= 1'b1;
                        state       <= StIssue;
                    end else if (dec_halt) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end else if ((dec_op == OP_WIDTH'(OP_LOOP)) && (loop_cnt != '0)) begin
                        loop_cnt <= loop_cnt - CNT_WIDTH'(1);
                        pc       <= dec_opnd[ADDR_WIDTH-1:0];
                        state    <= StFetch;
                    end else begin
                        if (dec_op == OP_WIDTH'(OP_SETCNT)) begin
                            loop_cnt <= dec_opnd[CNT_WIDTH-1:0];
                        end
                        if (dec_illegal) begin
                            err <= 1'b1;
                        end
                        if (pc_last) begin
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            pc    <= pc + ADDR_WIDTH'(1);
                            state <= StFetch;
                        end
                    end
                end
                StIssue: begin
                    if (!stall) begin
                        opcode      <= Nop;
                        instr_valid <= 1'b0;
                        if (pc_last) begin
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            pc    <= pc + ADDR_WIDTH'(1);
                            state <= StFetch;
                        end
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: directed programs plus random programs compared against
// a program-level interpreter of the instruction set.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        stall = 1'b0;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        busy;
    logic        done;
    logic        err;

    logic [15:0] mem [256];

    instr_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .stall      (stall),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .opcode     (opcode),
        .operand    (operand),
        .instr_valid(instr_valid),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference interpreter: walks the program by the instruction-set rules
    logic [15:0] exp_q[$];
    logic        exp_err;
    logic [7:0]  exp_pc;
    int          exp_fetches;
    bit          model_ok;

    task automatic run_model();
        int pc_m;
        int cnt;
        int op;
        int opnd;
        pc_m = 0;
        cnt = 0;
        exp_q.delete();
        exp_err = 1'b0;
        exp_pc = 8'h0;
        model_ok = 1'b0;
        exp_fetches = 0;
        while (exp_fetches < 1500) begin
            op   = int'(mem[pc_m][15:12]);
            opnd = int'(mem[pc_m][11:0]);
            exp_fetches++;
            if (op < 8 || (op == 15 && opnd != 'hFFF)) begin
                exp_q.push_back(mem[pc_m]);
            end else if (op == 15) begin
                exp_pc = 8'(pc_m);
                model_ok = 1'b1;
                break;
            end else if (op == 8 && cnt != 0) begin
                cnt--;
                pc_m = opnd % 256;
                continue;
            end else if (op == 9) begin
                cnt = opnd % 256;
            end else if (op > 9) begin
                exp_err = 1'b1;
            end
            if (pc_m == 255) begin
                exp_pc = 8'(pc_m);
                model_ok = 1'b1;
                break;
            end
            pc_m++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!instr_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_val({name, "/valid_seen"}, 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_val({name, "/idle_reached"}, 32'(busy), 32'd0);
    endtask

    task automatic run_prog(input string name, input int stall_pct);
        int  cyc;
        int  viol;
        int  issues;
        bit  fin;
        bit  st;
        logic [15:0] want;
        cyc = 0;
        viol = 0;
        issues = 0;
        fin = 1'b0;
        run_model();
        @(negedge clk);
        start = 1'b1;
        stall = ($urandom_range(0, 99) < stall_pct);
        @(negedge clk);
        start = 1'b0;
        check_val({name, "/err_cleared"}, 32'(err), 32'd0);
        check_val({name, "/first_fetch"}, {23'd0, imem_en, imem_addr}, {23'd0, 1'b1, 8'h00});
        while (!fin && cyc < 20 * exp_fetches + 100) begin
            cyc++;
            if (done) begin
                fin = 1'b1;
                check_val({name, "/issues_left"}, 32'(exp_q.size()), 32'd0);
                check_val({name, "/err_at_done"}, 32'(err), 32'(exp_err));
                check_val({name, "/pc_at_done"}, 32'(pc), 32'(exp_pc));
                if (stall_pct == 0)
                    check_val({name, "/cycles"}, 32'(cyc), 32'(2 * exp_fetches + issues + 1));
            end else begin
                if (!busy) viol++;
                if (!instr_valid && opcode != 4'hF) viol++;
                st = ($urandom_range(0, 99) < stall_pct);
                stall = st;
                if (instr_valid && !st) begin
                    issues++;
                    if (exp_q.size() == 0) begin
                        check_val({name, "/extra_issue"}, {opcode, operand}, 32'hFFFF_FFFF);
                    end else begin
                        want = exp_q.pop_front();
                        check_val({name, "/issue"}, {16'd0, opcode, operand}, {16'd0, want});
                    end
                end
                @(negedge clk);
            end
        end
        stall = 1'b0;
        if (!fin) check_val({name, "/timeout"}, 32'd0, 32'd1);
        check_val({name, "/nop_busy_invariant"}, 32'(viol), 32'd0);
        @(negedge clk);
        check_val({name, "/done_one_cycle"}, {30'd0, done, busy}, 32'd0);
    endtask

    task automatic gen_random();
        int len;
        int r;
        logic [11:0] o;
        model_ok = 1'b0;
        while (!model_ok) begin
            len = $urandom_range(4, 40);
            for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
            for (int a = 0; a < len; a++) begin
                r = $urandom_range(0, 99);
                o = 12'($urandom);
                if (r < 60)      mem[a] = {4'($urandom_range(0, 7)), o};
                else if (r < 68) mem[a] = {4'hF, (o == 12'hFFF) ? 12'h000 : o};
                else if (r < 78) mem[a] = {4'h9, 12'($urandom_range(0, 3))};
                else if (r < 90) mem[a] = {4'h8, 12'($urandom_range(0, a))};
                else if (r < 96) mem[a] = {4'($urandom_range(10, 14)), o};
                else             mem[a] = 16'hFFFF;
            end
            mem[len] = 16'hFFFF;
            run_model();
        end
    endtask

    task automatic load3(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                         input logic [15:0] w3);
        for (int a = 0; a < 256; a++) mem[a] = 16'hFFFF;
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
        mem[3] = w3;
    endtask

    initial begin
        logic [15:0] held;
        logic [7:0]  held_pc;
        int          seen_done;

        #12;
        check_val("reset/outputs", {24'd0, busy, done, err, instr_valid, imem_en, 3'd0},
                  32'd0);
        check_val("reset/opcode", {20'd0, opcode, operand}, 32'h0000_F000);
        check_val("reset/pc", 32'(pc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        load3(16'h0005, 16'h1003, 16'hFFFF, 16'hFFFF);
        run_prog("basic", 0);

        load3(16'h9002, 16'h2001, 16'h8001, 16'hFFFF);
        run_prog("loop", 0);

        load3(16'hA000, 16'h0001, 16'hFFFF, 16'hFFFF);
        run_prog("illegal", 0);
        repeat (2) @(negedge clk);
        check_val("illegal/err_sticky", 32'(err), 32'd1);

        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        run_prog("nohalt", 0);

        // Stall held for 5 cycles during the first issue
        load3(16'h0005, 16'h1003, 16'hFFFF, 16'hFFFF);
        pulse_start();
        wait_valid("stall");
        held = {opcode, operand};
        held_pc = pc;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) stall = 1'b0;
            check_val("stall/held", {15'd0, instr_valid, opcode, operand}, {15'd0, 1'b1, held});
            check_val("stall/pc_held", 32'(pc), 32'(held_pc));
        end
        @(negedge clk);
        check_val("stall/released", {27'd0, instr_valid, opcode}, 32'h0000_000F);
        check_val("stall/next_fetch", {23'd0, imem_en, imem_addr},
                  {23'd0, 1'b1, held_pc + 8'd1});
        wait_idle("stall");

        // Abort during issue
        pulse_start();
        wait_valid("abort");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("abort/state", {26'd0, busy, instr_valid, opcode}, 32'h0000_000F);
        seen_done = 0;
        repeat (5) begin
            if (done || busy) seen_done++;
            @(negedge clk);
        end
        check_val("abort/no_done", 32'(seen_done), 32'd0);
        run_prog("abort_restart", 0);

        // Reset during decode
        pulse_start();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("rst/outputs", {24'd0, busy, done, err, instr_valid, imem_en, 3'd0}, 32'd0);
        check_val("rst/opcode_pc", {12'd0, pc, opcode, 8'd0}, 32'h0000_0F00);
        @(negedge clk);
        rst_n = 1'b1;
        run_prog("rst_restart", 0);

        for (int t = 0; t < 20; t++) begin
            gen_random();
            run_prog("random", (t < 4) ? 0 : 30);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
